// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

   localparam int unsigned BCD_W       = 4;
   localparam logic [3:0]  ADD3_THRESH = 4'd5;
   localparam logic [3:0]  ADD3_VAL    = 4'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

   // Smallest digit count whose decimal range covers every w-bit unsigned value.
   function automatic int unsigned bcd_digits(input int unsigned w);
      longint unsigned lim;
      longint unsigned pow10;
      int unsigned     d;
      lim   = 64'd1 << w;
      pow10 = 64'd1;
      d     = 0;
      for (int i = 0; i < 20; i++) begin
         if (pow10 < lim) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// Operand/result handshake bundle between a producer, the converter and its consumer.
interface binary_to_bcd_seq_if #(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
) ();

   logic                                in_valid;
   logic                                in_ready;
   logic [BIN_W-1:0]                    in_bin;
   logic                                out_valid;
   logic                                out_ready;
   logic [bcd_pkg::BCD_W*DIGITS-1:0]    out_bcd;
   logic                                out_neg;

   modport master (
      output in_valid, in_bin, out_ready,
      input  in_ready, out_valid, out_bcd, out_neg
   );

   modport slave (
      input  in_valid, in_bin, out_ready,
      output in_ready, out_valid, out_bcd, out_neg
   );

endinterface

// File: rtl/binary_to_bcd_seq_digit_adj.sv
// One BCD digit of the add-3 correction applied before each shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] i_digit,
   output logic [BCD_W-1:0] o_digit_c
);

   assign o_digit_c = (i_digit >= ADD3_THRESH) ? (i_digit + ADD3_VAL) : i_digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, valid/ready on both sides.
module binary_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3,
   parameter bit          SIGNED = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   binary_to_bcd_seq_if.slave  bus
);

   localparam int unsigned ACC_W = BCD_W * DIGITS;
   localparam int unsigned CAT_W = ACC_W + BIN_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   if ((BIN_W < 2) || (BIN_W > 32) || (DIGITS < bcd_digits(BIN_W))) begin : g_bad_params
      $error("binary_to_bcd_seq: BIN_W must be 2..32 and DIGITS must cover 2**BIN_W");
   end

   bcd_state_t         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIN_W-1:0]   r_shreg;
   logic [ACC_W-1:0]   r_acc;
   logic               r_neg;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_out_bcd;
   logic               r_out_neg;

   logic               w_is_neg;
   logic [BIN_W-1:0]   w_mag;
   logic [ACC_W-1:0]   w_acc_adj;
   logic [CAT_W-1:0]   w_cat;
   logic               w_accept;

   // BIN_W-bit negation already yields 2**(BIN_W-1) as an unsigned magnitude for the most negative input.
   assign w_is_neg = SIGNED && bus.in_bin[BIN_W-1];
   assign w_mag    = w_is_neg ? (~bus.in_bin + BIN_W'(1)) : bus.in_bin;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit   (r_acc[g*BCD_W +: BCD_W]),
         .o_digit_c (w_acc_adj[g*BCD_W +: BCD_W])
      );
   end

   assign w_cat = {w_acc_adj, r_shreg} << 1;

   assign bus.in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_bcd   = r_out_bcd;
   assign bus.out_neg   = r_out_neg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shreg     <= '0;
         r_acc       <= '0;
         r_neg       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_bcd   <= '0;
         r_out_neg   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
            end
            SHIFT: begin
               r_acc   <= w_cat[CAT_W-1:BIN_W];
               r_shreg <= w_cat[BIN_W-1:0];
               r_cnt   <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_out_bcd   <= w_cat[CAT_W-1:BIN_W];
                  r_out_neg   <= r_neg;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Acceptance (from IDLE or a consumed DONE) overrides the state update above.
         if (w_accept) begin
            r_state <= SHIFT;
            r_cnt   <= CNT_W'(BIN_W);
            r_shreg <= w_mag;
            r_acc   <= '0;
            r_neg   <= w_is_neg;
         end
      end
   end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed and randomised checks of binary_to_bcd_seq across unsigned/signed and 8/12/16-bit builds.
module tb_binary_to_bcd_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        tb_valid [4];
   logic        tb_ready [4];
   logic [15:0] tb_bin   [4];
   logic        ir       [4];
   logic        ov       [4];
   logic        oneg     [4];
   logic [19:0] obcd     [4];

   int n_chk  = 0;
   int n_fail = 0;

   int unsigned bw [4] = '{8, 8, 16, 12};
   bit          sg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   binary_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if0 ();
   binary_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if1 ();
   binary_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if2 ();
   binary_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) if3 ();

   binary_to_bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   binary_to_bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));
   binary_to_bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1'b1)) dut3 (.clk(clk), .rst(rst), .bus(if3));

   assign if0.in_valid = tb_valid[0];  assign if0.out_ready = tb_ready[0];  assign if0.in_bin = tb_bin[0][7:0];
   assign if1.in_valid = tb_valid[1];  assign if1.out_ready = tb_ready[1];  assign if1.in_bin = tb_bin[1][7:0];
   assign if2.in_valid = tb_valid[2];  assign if2.out_ready = tb_ready[2];  assign if2.in_bin = tb_bin[2];
   assign if3.in_valid = tb_valid[3];  assign if3.out_ready = tb_ready[3];  assign if3.in_bin = tb_bin[3][11:0];

   assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign oneg[0] = if0.out_neg;  assign obcd[0] = 20'(if0.out_bcd);
   assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign oneg[1] = if1.out_neg;  assign obcd[1] = 20'(if1.out_bcd);
   assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign oneg[2] = if2.out_neg;  assign obcd[2] = 20'(if2.out_bcd);
   assign ir[3] = if3.in_ready;  assign ov[3] = if3.out_valid;  assign oneg[3] = if3.out_neg;  assign obcd[3] = 20'(if3.out_bcd);

   // Reference: decimal digits by repeated division of the magnitude.
   function automatic logic [19:0] ref_bcd(input int d, input logic [15:0] v, output logic neg);
      int unsigned m;
      logic [19:0] r;
      m   = 32'(v) & ((32'd1 << bw[d]) - 32'd1);
      neg = sg[d] && (((m >> (bw[d] - 1)) & 32'd1) == 32'd1);
      if (neg) m = (32'd1 << bw[d]) - m;
      r = '0;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   // Present v and hold in_valid until accepted; returns at the negedge after the accepting edge.
   task automatic send(input int d, input logic [15:0] v);
      int n;
      n = 0;
      @(negedge clk);
      tb_bin[d]   = v;
      tb_valid[d] = 1'b1;
      while (!ir[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (n >= 100) begin
         n_fail++;
         $display("FAIL send_timeout dut%0d: in_ready got 0, want 1", d);
      end
      @(negedge clk);
      tb_valid[d] = 1'b0;
   endtask

   task automatic wait_out(input int d, output int lat);
      lat = 0;
      while (!ov[d] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      n_chk++;
      if (!ov[d]) begin
         n_fail++;
         $display("FAIL out_timeout dut%0d: out_valid got 0, want 1", d);
      end
   endtask

   task automatic pop(input int d);
      tb_ready[d] = 1'b1;
      @(negedge clk);
      tb_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         n_chk++; if (ov[d] !== 1'b0)    begin n_fail++; $display("FAIL rst_out_valid dut%0d: got %b want 0", d, ov[d]); end
         n_chk++; if (obcd[d] !== 20'h0) begin n_fail++; $display("FAIL rst_out_bcd dut%0d: got %h want 0", d, obcd[d]); end
         n_chk++; if (oneg[d] !== 1'b0)  begin n_fail++; $display("FAIL rst_out_neg dut%0d: got %b want 0", d, oneg[d]); end
         n_chk++; if (ir[d] !== 1'b0)    begin n_fail++; $display("FAIL rst_in_ready dut%0d: got %b want 0", d, ir[d]); end
      end
      rst = 1'b0;
      #1;
      for (int d = 0; d < 4; d++) begin
         n_chk++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready dut%0d: got %b want 1", d, ir[d]); end
      end
   endtask

   task automatic test_unsigned_max();
      int lat;
      send(0, 16'd255);
      wait_out(0, lat);
      n_chk++; if (lat != 8)             begin n_fail++; $display("FAIL u255_latency: got %0d want 8", lat); end
      n_chk++; if (obcd[0] !== 20'h00255) begin n_fail++; $display("FAIL u255_bcd: got %h want 00255", obcd[0]); end
      n_chk++; if (oneg[0] !== 1'b0)      begin n_fail++; $display("FAIL u255_neg: got %b want 0", oneg[0]); end
      pop(0);
      n_chk++; if (ov[0] !== 1'b0)        begin n_fail++; $display("FAIL u255_drop: out_valid got %b want 0", ov[0]); end
   endtask

   task automatic test_zero_and_hold();
      int lat;
      bit seen;
      send(0, 16'd0);
      wait_out(0, lat);
      n_chk++; if (obcd[0] !== 20'h00000) begin n_fail++; $display("FAIL zero_bcd: got %h want 00000", obcd[0]); end
      pop(0);
      send(0, 16'd100);
      // New operand offered mid-conversion and during the hold must be ignored.
      tb_bin[0]   = 16'd55;
      tb_valid[0] = 1'b1;
      n_chk++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL shift_in_ready: got %b want 0", ir[0]); end
      wait_out(0, lat);
      for (int c = 0; c < 5; c++) begin
         n_chk++; if (ov[0] !== 1'b1)        begin n_fail++; $display("FAIL hold_valid c%0d: got %b want 1", c, ov[0]); end
         n_chk++; if (obcd[0] !== 20'h00100) begin n_fail++; $display("FAIL hold_bcd c%0d: got %h want 00100", c, obcd[0]); end
         n_chk++; if (ir[0] !== 1'b0)        begin n_fail++; $display("FAIL hold_in_ready c%0d: got %b want 0", c, ir[0]); end
         @(negedge clk);
      end
      tb_valid[0] = 1'b0;
      pop(0);
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (ov[0]) seen = 1'b1;
         @(negedge clk);
      end
      n_chk++; if (seen) begin n_fail++; $display("FAIL hold_ignored_input: out_valid got 1, want 0"); end
   endtask

   task automatic test_signed();
      logic [15:0] vin  [4] = '{16'h80, 16'hFF, 16'h7F, 16'h00};
      logic [19:0] vexp [4] = '{20'h00128, 20'h00001, 20'h00127, 20'h00000};
      logic        nexp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 4; i++) begin
         send(1, vin[i]);
         wait_out(1, lat);
         n_chk++; if (obcd[1] !== vexp[i]) begin n_fail++; $display("FAIL signed_bcd %h: got %h want %h", vin[i], obcd[1], vexp[i]); end
         n_chk++; if (oneg[1] !== nexp[i]) begin n_fail++; $display("FAIL signed_neg %h: got %b want %b", vin[i], oneg[1], nexp[i]); end
         pop(1);
      end
      send(3, 16'h0800);
      wait_out(3, lat);
      n_chk++; if (obcd[3] !== 20'h02048) begin n_fail++; $display("FAIL s12_min_bcd: got %h want 02048", obcd[3]); end
      n_chk++; if (oneg[3] !== 1'b1)      begin n_fail++; $display("FAIL s12_min_neg: got %b want 1", oneg[3]); end
      pop(3);
   endtask

   task automatic test_wide();
      int lat;
      send(2, 16'hFFFF);
      wait_out(2, lat);
      n_chk++; if (lat != 16)             begin n_fail++; $display("FAIL w16_latency: got %0d want 16", lat); end
      n_chk++; if (obcd[2] !== 20'h65535) begin n_fail++; $display("FAIL w16_max_bcd: got %h want 65535", obcd[2]); end
      pop(2);
      send(2, 16'd1000);
      wait_out(2, lat);
      n_chk++; if (obcd[2] !== 20'h01000) begin n_fail++; $display("FAIL w16_1000_bcd: got %h want 01000", obcd[2]); end
      pop(2);
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [3] = '{16'd7, 16'd42, 16'd199};
      logic [19:0] vexp [3] = '{20'h00007, 20'h00042, 20'h00199};
      int          tres [3];
      logic [19:0] vres [3];
      int          idx, nres;
      logic        pend;
      idx  = 0;
      nres = 0;
      @(negedge clk);
      tb_bin[0]   = vals[0];
      tb_valid[0] = 1'b1;
      tb_ready[0] = 1'b1;
      pend        = ir[0];
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (ov[0] && nres < 3) begin
            tres[nres] = c;
            vres[nres] = obcd[0];
            nres++;
         end
         if (pend) begin
            idx++;
            if (idx < 3) tb_bin[0] = vals[idx];
            else         tb_valid[0] = 1'b0;
         end
         pend = tb_valid[0] && ir[0];
      end
      tb_valid[0] = 1'b0;
      tb_ready[0] = 1'b0;
      n_chk++; if (nres != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", nres); end
      for (int i = 0; i < 3; i++) begin
         if (i < nres) begin
            n_chk++; if (vres[i] !== vexp[i]) begin n_fail++; $display("FAIL b2b_bcd%0d: got %h want %h", i, vres[i], vexp[i]); end
         end
         if (i > 0 && i < nres) begin
            n_chk++; if (tres[i] - tres[i-1] != 9) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 9", i, tres[i] - tres[i-1]); end
         end
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      bit seen;
      send(0, 16'd77);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_chk++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready_rst: got %b want 0", ir[0]); end
      @(negedge clk);
      n_chk++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", ov[0]); end
      rst = 1'b0;
      #1;
      n_chk++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", ir[0]); end
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ov[0]) seen = 1'b1;
      end
      n_chk++; if (seen) begin n_fail++; $display("FAIL abort_discard: out_valid got 1, want 0"); end
      send(0, 16'd12);
      wait_out(0, lat);
      n_chk++; if (obcd[0] !== 20'h00012) begin n_fail++; $display("FAIL abort_next_bcd: got %h want 00012", obcd[0]); end
      pop(0);
   endtask

   task automatic test_random();
      int          sel [3] = '{0, 1, 3};
      int          d, lat;
      logic [15:0] v;
      logic [19:0] exp_bcd;
      logic        exp_neg;
      for (int s = 0; s < 3; s++) begin
         d = sel[s];
         for (int i = 0; i < 25; i++) begin
            v = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(d, v);
            exp_bcd = ref_bcd(d, v, exp_neg);
            wait_out(d, lat);
            n_chk++; if (lat != int'(bw[d])) begin n_fail++; $display("FAIL rnd_latency dut%0d %h: got %0d want %0d", d, v, lat, bw[d]); end
            n_chk++; if (obcd[d] !== exp_bcd) begin n_fail++; $display("FAIL rnd_bcd dut%0d %h: got %h want %h", d, v, obcd[d], exp_bcd); end
            n_chk++; if (oneg[d] !== exp_neg) begin n_fail++; $display("FAIL rnd_neg dut%0d %h: got %b want %b", d, v, oneg[d], exp_neg); end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pop(d);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         tb_valid[d] = 1'b0;
         tb_ready[d] = 1'b0;
         tb_bin[d]   = 16'h0;
      end
      test_reset();
      test_unsigned_max();
      test_zero_and_hold();
      test_signed();
      test_wide();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
